uart_rx_ctrl: RTL and testbench

// - Sequences the UART receiver. Generates the 16x oversampling s_tick from a programmable divisor.
// - Captures each received byte on rx_done_tick into a receive FIFO and offers it on a valid/ready port.
// - Flags overrun when a byte is lost. Raises a character-timeout flag when data sits unread with the line quiet.
// - Sits between the rx deserialiser and the host/register interface.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_ctrl_if.sv | 8 +
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_rx_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver constants and controller state encoding
package uart_pkg;

    localparam int UART_OVS           = 16;
    localparam int UART_BITS_PER_CHAR = 10;
    localparam int UART_TO_CHARS      = 4;
    localparam int UART_TO_TICKS_DEF  = UART_TO_CHARS * UART_BITS_PER_CHAR * UART_OVS;

    localparam logic [1:0] ST_OFF_ENC   = 2'd0;
    localparam logic [1:0] ST_EMPTY_ENC = 2'd1;
    localparam logic [1:0] ST_HOLD_ENC  = 2'd2;
    localparam logic [1:0] ST_TMO_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF   = ST_OFF_ENC,
        ST_EMPTY = ST_EMPTY_ENC,
        ST_HOLD  = ST_HOLD_ENC,
        ST_TMO   = ST_TMO_ENC
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: valid/ready byte stream from the receive FIFO to the host
interface uart_rx_ctrl_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: DEPTH x 8 first-word-fall-through FIFO with occupancy count
module uart_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // next pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_i) - CW'(pop_i);
    end

    // storage is not reset; stale entries are hidden by the count
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling tick generator, receive FIFO, overrun and character-timeout control
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int DEPTH    = 16,
    parameter int TO_TICKS = UART_TO_TICKS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_en_i,
    input  logic [DIV_W-1:0]       cfg_div_i,
    output logic                   s_tick_o,
    input  logic                   rx_done_tick_i,
    input  logic [7:0]             rx_data_i,
    uart_rx_ctrl_if.master         m_if,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   overrun_o,
    input  logic                   clr_overrun_i,
    output logic                   timeout_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TO_TICKS);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_en, tick_wrap;
    logic [CW-1:0]    count, count_nx;
    logic [7:0]       fifo_rdata;
    logic             full, pop, push, drop;
    logic             overrun_q, overrun_d;
    rx_state_e        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;

    assign tick_en   = cfg_en_i && (cfg_div_i != '0);
    assign tick_wrap = div_cnt_q >= cfg_div_i - DIV_W'(1);
    assign s_tick_o  = tick_en && (div_cnt_q == cfg_div_i - DIV_W'(1));

    // divisor counter; a shrinking divisor that leaves the count past the end forces a wrap
    always_comb begin
        div_cnt_d = (!tick_en || tick_wrap) ? '0 : div_cnt_q + DIV_W'(1);
    end

    assign full     = count == CW'(DEPTH);
    assign pop      = m_if.m_valid && m_if.m_ready;
    assign push     = rx_done_tick_i && cfg_en_i && (!full || pop);
    assign drop     = rx_done_tick_i && cfg_en_i && full && !pop;
    assign count_nx = count + CW'(push) - CW'(pop);

    uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (rx_data_i),
        .rdata_o (fifo_rdata),
        .count_o (count)
    );

    assign m_if.m_data  = fifo_rdata;
    assign m_if.m_valid = count != '0;
    assign fifo_count_o = count;

    // sticky overrun; a fresh drop outranks a clear in the same cycle
    always_comb begin
        overrun_d = drop ? 1'b1 : clr_overrun_i ? 1'b0 : overrun_q;
    end

    // timeout FSM: the timer only runs while unread data sits in the FIFO
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!cfg_en_i) begin
            state_d = ST_OFF;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_EMPTY;
                    timer_d = '0;
                end
                ST_EMPTY: begin
                    if (count_nx != '0) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (count_nx == '0) begin
                        state_d = ST_EMPTY;
                        timer_d = '0;
                    end else if (push || pop) begin
                        timer_d = '0;
                    end else if (s_tick_o) begin
                        if (timer_q == TW'(TO_TICKS - 1)) begin
                            state_d = ST_TMO;
                            timer_d = '0;
                        end else if (timer_q != '1) begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                ST_TMO: begin
                    if (push) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                    end else if (count_nx == '0) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            overrun_q <= 1'b0;
            state_q   <= ST_OFF;
            timer_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
        end
    end

    assign overrun_o = overrun_q;
    assign timeout_o = state_q == ST_TMO;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized self-checking bench against a queue-based reference model
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int TO    = 640;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        rx = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [15:0] div = 16'd0;
    logic        s_tick, overrun, timeout;
    logic [4:0]  fifo_count;

    int          n_chk = 0;
    int          n_pass = 0;
    byte unsigned q[$];
    bit          ovr = 1'b0;
    int          mph = 0;
    int          nticks = 0;
    bit          exp_tick, obs_tick, exp_pop, obs_pop;
    logic [7:0]  exp_byte, obs_byte;

    uart_rx_ctrl_if rx_if();

    uart_rx_ctrl #(.DIV_W(16), .DEPTH(DEPTH), .TO_TICKS(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_en_i       (en),
        .cfg_div_i      (div),
        .s_tick_o       (s_tick),
        .rx_done_tick_i (rx),
        .rx_data_i      (data),
        .m_if           (rx_if),
        .fifo_count_o   (fifo_count),
        .overrun_o      (overrun),
        .clr_overrun_i  (clr),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    // one clock: predict from the spec rules with the current inputs, then advance
    task automatic cycle();
        int d;
        bit pop, push, drop;
        #1;
        d = int'(div);
        obs_tick = s_tick;
        exp_tick = en && d != 0 && mph == d - 1;
        mph = (!en || d == 0 || mph >= d - 1) ? 0 : mph + 1;
        if (exp_tick) nticks++;
        obs_pop = rx_if.m_valid && rx_if.m_ready;
        obs_byte = rx_if.m_data;
        pop = q.size() != 0 && rx_if.m_ready;
        push = rx && en && (q.size() < DEPTH || pop);
        drop = rx && en && q.size() == DEPTH && !pop;
        exp_pop = pop;
        if (pop) exp_byte = q.pop_front();
        if (push) q.push_back(data);
        ovr = drop ? 1'b1 : clr ? 1'b0 : ovr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (rx_if.m_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", rx_if.m_valid); else n_pass++;
        n_chk++; if (rx_if.m_data !== 8'h00) $display("FAIL reset_data: got %h exp 00", rx_if.m_data); else n_pass++;
        n_chk++; if (fifo_count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", fifo_count); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b exp 0", overrun); else n_pass++;
        n_chk++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b exp 0", timeout); else n_pass++;
        n_chk++; if (s_tick !== 1'b0) $display("FAIL reset_stick: got %b exp 0", s_tick); else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_tick();
        int cnt = 0;
        en = 1'b1; div = 16'd4;
        for (int i = 0; i < 40; i++) begin
            cycle();
            cnt += obs_tick;
            n_chk++; if (obs_tick !== exp_tick) $display("FAIL tick_div4 cyc %0d: got %b exp %b", i, obs_tick, exp_tick); else n_pass++;
        end
        n_chk++; if (cnt != 10) $display("FAIL tick_div4_count: got %0d exp 10", cnt); else n_pass++;
        div = 16'd0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_chk++; if (obs_tick !== 1'b0) $display("FAIL tick_div0 cyc %0d: got %b exp 0", i, obs_tick); else n_pass++;
        end
        div = 16'd1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_chk++; if (obs_tick !== 1'b1) $display("FAIL tick_div1 cyc %0d: got %b exp 1", i, obs_tick); else n_pass++;
        end
        en = 1'b0; div = 16'd4;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_chk++; if (obs_tick !== 1'b0) $display("FAIL tick_dis cyc %0d: got %b exp 0", i, obs_tick); else n_pass++;
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_chk++; if (obs_tick !== (i == 3)) $display("FAIL tick_restart cyc %0d: got %b exp %b", i, obs_tick, i == 3); else n_pass++;
        end
        div = 16'd8;
        repeat (5) cycle();
        div = 16'd3;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_chk++; if (obs_tick !== exp_tick) $display("FAIL tick_divchg cyc %0d: got %b exp %b", i, obs_tick, exp_tick); else n_pass++;
        end
        en = 1'b0;
        cycle();
    endtask

    task automatic test_latency();
        en = 1'b1; div = 16'd0;
        rx = 1'b1; data = 8'hA5;
        cycle();
        rx = 1'b0;
        n_chk++; if (rx_if.m_valid !== 1'b1) $display("FAIL lat_valid: got %b exp 1", rx_if.m_valid); else n_pass++;
        n_chk++; if (rx_if.m_data !== 8'hA5) $display("FAIL lat_data: got %h exp a5", rx_if.m_data); else n_pass++;
        n_chk++; if (fifo_count !== 5'd1) $display("FAIL lat_count: got %0d exp 1", fifo_count); else n_pass++;
        rx_if.m_ready = 1'b1;
        cycle();
        rx_if.m_ready = 1'b0;
        n_chk++; if (obs_byte !== 8'hA5) $display("FAIL lat_pop_data: got %h exp a5", obs_byte); else n_pass++;
        n_chk++; if (rx_if.m_valid !== 1'b0) $display("FAIL lat_empty: got %b exp 0", rx_if.m_valid); else n_pass++;
    endtask

    task automatic test_order();
        logic [7:0] got[$];
        en = 1'b1; rx_if.m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rx = 1'b1; data = 8'(i);
            cycle();
            if (obs_pop) got.push_back(obs_byte);
        end
        rx = 1'b0;
        repeat (4) begin
            cycle();
            if (obs_pop) got.push_back(obs_byte);
        end
        rx_if.m_ready = 1'b0;
        n_chk++; if (got.size() != 40) $display("FAIL order_len: got %0d exp 40", got.size()); else n_pass++;
        for (int i = 0; i < got.size(); i++) begin
            n_chk++; if (got[i] !== 8'(i)) $display("FAIL order_byte %0d: got %h exp %h", i, got[i], 8'(i)); else n_pass++;
        end
        n_chk++; if (overrun !== 1'b0) $display("FAIL order_overrun: got %b exp 0", overrun); else n_pass++;
    endtask

    task automatic test_overrun();
        en = 1'b1; rx_if.m_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            rx = 1'b1; data = 8'($urandom);
            cycle();
        end
        rx = 1'b0;
        n_chk++; if (fifo_count !== 5'd16) $display("FAIL ovr_count: got %0d exp 16", fifo_count); else n_pass++;
        n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b exp 1", overrun); else n_pass++;
        rx = 1'b1; clr = 1'b1; data = 8'($urandom);
        cycle();
        n_chk++; if (overrun !== ovr) $display("FAIL ovr_clr_vs_new: got %b exp %b", overrun, ovr); else n_pass++;
        rx = 1'b0;
        cycle();
        clr = 1'b0;
        n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b exp 0", overrun); else n_pass++;
        rx_if.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_chk++; if (obs_pop !== exp_pop || obs_byte !== exp_byte) $display("FAIL ovr_drain %0d: got %b/%h exp %b/%h", i, obs_pop, obs_byte, exp_pop, exp_byte); else n_pass++;
        end
        rx_if.m_ready = 1'b0;
        n_chk++; if (fifo_count !== 5'd0) $display("FAIL ovr_drained: got %0d exp 0", fifo_count); else n_pass++;
    endtask

    task automatic test_full_pushpop();
        en = 1'b1; rx_if.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rx = 1'b1; data = 8'($urandom);
            cycle();
        end
        rx_if.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data = 8'($urandom);
            cycle();
            n_chk++; if (obs_byte !== exp_byte) $display("FAIL full_pp_head %0d: got %h exp %h", i, obs_byte, exp_byte); else n_pass++;
            n_chk++; if (fifo_count !== 5'd16) $display("FAIL full_pp_count %0d: got %0d exp 16", i, fifo_count); else n_pass++;
            n_chk++; if (overrun !== 1'b0) $display("FAIL full_pp_overrun %0d: got %b exp 0", i, overrun); else n_pass++;
        end
        rx = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_chk++; if (obs_byte !== exp_byte) $display("FAIL full_pp_drain %0d: got %h exp %h", i, obs_byte, exp_byte); else n_pass++;
        end
        rx_if.m_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int guard;
        en = 1'b1; div = 16'($urandom_range(1, 3)); rx_if.m_ready = 1'b0;
        rx = 1'b1; data = 8'h11;
        cycle();
        rx = 1'b0; nticks = 0; guard = 0;
        while (nticks < TO && guard < 4 * TO) begin
            cycle(); guard++;
            n_chk++; if (timeout !== (nticks >= TO)) $display("FAIL tmo_single tick %0d: got %b exp %b", nticks, timeout, nticks >= TO); else n_pass++;
        end
        n_chk++; if (nticks != TO) $display("FAIL tmo_single_bound: got %0d ticks exp %0d", nticks, TO); else n_pass++;
        rx_if.m_ready = 1'b1;
        cycle();
        rx_if.m_ready = 1'b0;
        n_chk++; if (timeout !== 1'b0) $display("FAIL tmo_pop_clear: got %b exp 0", timeout); else n_pass++;
        rx = 1'b1; data = 8'h22;
        cycle();
        rx = 1'b0; nticks = 0; guard = 0;
        while (nticks < TO - 1 && guard < 4 * TO) begin
            cycle(); guard++;
        end
        rx = 1'b1; data = 8'h33;
        cycle();
        rx = 1'b0; nticks = 0; guard = 0;
        n_chk++; if (timeout !== 1'b0) $display("FAIL tmo_push639: got %b exp 0", timeout); else n_pass++;
        while (nticks < TO && guard < 4 * TO) begin
            cycle(); guard++;
            n_chk++; if (timeout !== (nticks >= TO)) $display("FAIL tmo_rearm tick %0d: got %b exp %b", nticks, timeout, nticks >= TO); else n_pass++;
        end
        n_chk++; if (nticks != TO) $display("FAIL tmo_rearm_bound: got %0d ticks exp %0d", nticks, TO); else n_pass++;
        rx_if.m_ready = 1'b1;
        cycle();
        rx_if.m_ready = 1'b0;
        n_chk++; if (obs_byte !== 8'h22) $display("FAIL tmo_pop_head: got %h exp 22", obs_byte); else n_pass++;
        n_chk++; if (timeout !== 1'b1) $display("FAIL tmo_pop_keep: got %b exp 1", timeout); else n_pass++;
        en = 1'b0;
        cycle();
        n_chk++; if (timeout !== 1'b0) $display("FAIL tmo_disable: got %b exp 0", timeout); else n_pass++;
        rx_if.m_ready = 1'b1;
        cycle();
        rx_if.m_ready = 1'b0;
        n_chk++; if (obs_byte !== 8'h33 || fifo_count !== 5'd0) $display("FAIL tmo_off_pop: got %h/%0d exp 33/0", obs_byte, fifo_count); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 9) != 0;
            div = 16'($urandom_range(0, 5));
            rx = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            rx_if.m_ready = $urandom_range(0, 9) < 4;
            clr = $urandom_range(0, 9) == 0;
            cycle();
            n_chk++; if (obs_tick !== exp_tick) $display("FAIL rnd_tick %0d: got %b exp %b", i, obs_tick, exp_tick); else n_pass++;
            n_chk++; if (fifo_count !== 5'(q.size())) $display("FAIL rnd_count %0d: got %0d exp %0d", i, fifo_count, q.size()); else n_pass++;
            n_chk++; if (rx_if.m_valid !== (q.size() != 0)) $display("FAIL rnd_valid %0d: got %b exp %b", i, rx_if.m_valid, q.size() != 0); else n_pass++;
            n_chk++; if (overrun !== ovr) $display("FAIL rnd_overrun %0d: got %b exp %b", i, overrun, ovr); else n_pass++;
            if (q.size() != 0) begin
                n_chk++; if (rx_if.m_data !== q[0]) $display("FAIL rnd_data %0d: got %h exp %h", i, rx_if.m_data, q[0]); else n_pass++;
            end
        end
        en = 1'b1; rx = 1'b0; clr = 1'b1; rx_if.m_ready = 1'b1;
        repeat (20) cycle();
        n_chk++; if (fifo_count !== 5'd0 || overrun !== 1'b0) $display("FAIL rnd_final: got %0d/%b exp 0/0", fifo_count, overrun); else n_pass++;
    endtask

    initial begin
        rx_if.m_ready = 1'b0;
        test_reset();
        test_tick();
        test_latency();
        test_order();
        test_overrun();
        test_full_pushpop();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
